// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues pair-aligned local-store reads with 1-cycle latency,
// queues returned instruction pairs and presents the head to decode.
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned LS_BYTES = 32768
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ls_rd_en,
    output logic [0:31] ls_addr,
    input  logic [0:63] ls_rd_data,
    input  logic        dep_stall,
    input  logic        flush,
    input  logic [0:31] branch_target,
    output logic [0:63] instr_pair,
    output logic [0:1]  slot_mask,
    output logic [0:31] pc_out,
    output logic        instr_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [31:0] LS_SIZE = 32'(LS_BYTES);
    localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(DEPTH);

    typedef enum logic [1:0] {FLUSHED, FETCH, FULL} state_t;

    typedef struct packed {
        logic [0:63] pair;
        logic [0:31] pc;
        logic [0:1]  mask;
    } entry_t;

    function automatic logic [31:0] wrap_pc(input logic [31:0] a);
        return a % LS_SIZE;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic               odd_q, odd_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    entry_t             fifo_q [DEPTH];
    entry_t             push_entry_d;
    entry_t             head;

    logic [PTR_W+1:0]   used_credits;
    logic               credit_ok;
    logic               has_data;
    logic               push;
    logic               pop;
    logic               req;

    // Credits include the return in flight so a push can never land on a full FIFO.
    always_comb begin
        used_credits = {1'b0, count_q} + {{(PTR_W+1){1'b0}}, inflight_q};
        credit_ok    = (used_credits < DEPTH_C);
        has_data     = (count_q != '0);
        push         = inflight_q && !flush;
        pop          = has_data && !dep_stall && !flush;
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            FLUSHED: state_d = FETCH;
            FETCH: begin
                if (credit_ok) req = 1'b1;
                else           state_d = FULL;
            end
            FULL: begin
                if (credit_ok) state_d = FETCH;
            end
            default: state_d = FLUSHED;
        endcase
        if (flush) begin
            state_d = FLUSHED;
            req     = 1'b0;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = req;
        odd_d      = odd_q;
        req_pc_d   = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            fetch_pc_d = wrap_pc(32'(branch_target) & 32'hFFFF_FFF8);
            odd_d      = branch_target[29];
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req)  fetch_pc_d = wrap_pc(fetch_pc_q + 32'd8);
            if (push) begin
                odd_d    = 1'b0;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_comb begin
        push_entry_d.pair = ls_rd_data;
        push_entry_d.pc   = req_pc_q;
        push_entry_d.mask = odd_q ? 2'b01 : 2'b11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FLUSHED;
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            odd_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            odd_q      <= odd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        if (push) fifo_q[wr_ptr_q] <= push_entry_d;
    end

    always_comb begin
        head        = fifo_q[rd_ptr_q];
        ls_rd_en    = req;
        ls_addr     = fetch_pc_q;
        instr_valid = has_data;
        instr_pair  = has_data ? head.pair : '0;
        pc_out      = has_data ? head.pc   : '0;
        slot_mask   = has_data ? head.mask : 2'b00;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed plus randomized bench for fetch_buffer, checked against a queue-based
// reference model of the fetch/buffer rules.
module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          LS       = 32768;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ls_rd_en;
    logic [0:31] ls_addr;
    logic [0:63] ls_rd_data = '0;
    logic        dep_stall = 1'b0;
    logic        flush = 1'b0;
    logic [0:31] branch_target = '0;
    logic [0:63] instr_pair;
    logic [0:1]  slot_mask;
    logic [0:31] pc_out;
    logic        instr_valid;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .LS_BYTES(LS)) dut (
        .clk(clk), .rst(rst), .ls_rd_en(ls_rd_en), .ls_addr(ls_addr),
        .ls_rd_data(ls_rd_data), .dep_stall(dep_stall), .flush(flush),
        .branch_target(branch_target), .instr_pair(instr_pair),
        .slot_mask(slot_mask), .pc_out(pc_out), .instr_valid(instr_valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  mask;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_inpc;
    bit          m_inflight, m_odd, m_bubble, m_blocked;
    logic        rd_pend;
    logic [31:0] rd_addr;
    logic        s_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Memory word n holds value n, so a pair at byte address a is {a/4, a/4+1}.
    function automatic logic [63:0] mem_pair(input logic [31:0] a);
        return {a >> 2, (a >> 2) + 32'd1};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc       = RESET_PC;
        m_inpc     = '0;
        m_inflight = 0;
        m_odd      = 0;
        m_bubble   = 1;
        m_blocked  = 0;
        rd_pend    = 1'b0;
        rd_addr    = '0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ls_rd_en", ls_rd_en, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_slot_mask", slot_mask, 0);
        chk("rst_instr_pair", instr_pair, 0);
        chk("rst_pc_out", pc_out, 0);
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model, return data.
    task automatic cycle(input bit stall, input bit fl, input logic [31:0] tgt);
        bit   credit, req, pop;
        exp_t e;
        dep_stall     = stall;
        flush         = fl;
        branch_target = tgt;
        @(negedge clk);
        credit  = (mq.size() + int'(m_inflight)) < DEPTH;
        req     = !m_bubble && !m_blocked && credit && !fl;
        s_valid = instr_valid;
        chk("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("pc_out", pc_out, mq[0].pc);
            chk("slot_mask", slot_mask, mq[0].mask);
            chk("instr_pair", instr_pair, mem_pair(mq[0].pc));
        end else begin
            chk("slot_mask_empty", slot_mask, 0);
        end
        chk("ls_rd_en", ls_rd_en, req);
        if (req) chk("ls_addr", ls_addr, m_pc);
        rd_pend = ls_rd_en;
        rd_addr = ls_addr;
        pop = (mq.size() != 0) && !stall;
        if (fl) begin
            mq.delete();
            m_pc       = (tgt & 32'hFFFF_FFF8) % LS;
            m_odd      = tgt[2];
            m_inflight = 0;
            m_bubble   = 1;
            m_blocked  = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_inflight) begin
                e.pc   = m_inpc;
                e.mask = m_odd ? 2'b01 : 2'b11;
                mq.push_back(e);
                m_odd = 0;
            end
            if (m_bubble)                 m_bubble = 0;
            else if (!m_blocked && !credit) m_blocked = 1;
            else if (m_blocked && credit)   m_blocked = 0;
            m_inflight = req;
            if (req) begin
                m_inpc = m_pc;
                m_pc   = (m_pc + 32'd8) % LS;
            end
        end
        @(posedge clk);
        #1;
        ls_rd_data = rd_pend ? mem_pair(rd_addr) : {$urandom, $urandom};
    endtask

    task automatic fill_to(input int n);
        int k = 0;
        while (mq.size() != n && k < 30) begin
            cycle(1, 0, $urandom);
            k++;
        end
        if (mq.size() != n) begin
            n_err++;
            $error("FAIL fill_to: queue depth %0d, wanted %0d", mq.size(), n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        model_reset();
        #1 rst = 1'b1;
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // Stall from reset release: the first pair appears after 3 edges and the head holds.
        k = 0;
        while (k < 10) begin
            cycle(1, 0, 32'h0);
            if (s_valid) break;
            k++;
        end
        chk("first_valid_edges", k, 3);
        repeat (9) cycle(1, 0, 32'h0);
        repeat (10) cycle(0, 0, 32'h0);

        // Redirect to a word-odd target while a read is in flight.
        cycle(0, 1, 32'h104);
        repeat (8) cycle(0, 0, 32'h0);

        // Flush concurrent with stall while three entries are queued.
        fill_to(3);
        cycle(1, 1, 32'h200);
        repeat (6) cycle(0, 0, 32'h0);

        // Fetch address wraps at the top of local store.
        cycle(0, 1, 32'h7FF0);
        repeat (8) cycle(0, 0, 32'h0);

        // Asynchronous reset with two entries queued.
        cycle(0, 1, 32'h1000);
        fill_to(2);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        ls_rd_data = {$urandom, $urandom};
        repeat (6) cycle(0, 0, 32'h0);

        // Randomized traffic with back-pressure and occasional redirects.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 2) == 0, ($urandom % 25) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
